// File: rtl/dmem_wb_if.sv
// Request/response bundle for dmem_wb_responder.
// The requester uses the master modport and the memory block uses the slave modport.
interface dmem_wb_if #(
  parameter int unsigned AW = 7
) ();
  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [31:0]   D;
  logic          flush;
  logic [31:0]   Q;
  logic          q_valid;
  logic          busy;
  logic          drop_err;

  modport master (
    output CEN, WEN, OEN, A, D, flush,
    input  Q, q_valid, busy, drop_err
  );

  modport slave (
    input  CEN, WEN, OEN, A, D, flush,
    output Q, q_valid, busy, drop_err
  );
endinterface

// File: rtl/dmem_wb_responder.sv
// Single-port word memory fronted by a circular write buffer that drains in the background or on flush.
// Optional macro DMEM_WB_FWD_EN: reads forward the newest buffered write instead of stalling until the buffer is empty.
module dmem_wb_responder #(
  parameter int unsigned WB_DEPTH = 4,
  parameter int unsigned AW       = 7
) (
  input logic      clk,
  input logic      rst,
  dmem_wb_if.slave bus
);

  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = $clog2(WB_DEPTH);
  localparam int unsigned CW    = $clog2(WB_DEPTH + 1);
  localparam int unsigned WORDS = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [DW-1:0]   q_reg;
  logic            q_valid_q;
  logic            drop_err_q;

  wb_entry_t       wb_mem [WB_DEPTH];
  logic [DW-1:0]   mem    [WORDS];

  logic            busy_c;
  logic            wr_acc;
  logic            rd_acc;
  logic            rd_miss;
  logic            push;
  logic            pop;
  logic            hit;
  logic [DW-1:0]   rd_data;

`ifdef DMEM_WB_FWD_EN
  logic [DW-1:0]   hit_data;

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      if ((CW'(k) < count_q) && (wb_mem[PW'(rd_ptr_q + PW'(k))].addr == bus.A)) begin
        hit      = 1'b1;
        hit_data = wb_mem[PW'(rd_ptr_q + PW'(k))].data;
      end
    end
  end

  assign rd_data = hit ? hit_data : mem[bus.A];
`else
  assign hit     = 1'b0;
  assign rd_data = mem[bus.A];
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE only if entries remain after this cycle's pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush && (count_q != '0) && (count_d != '0)) state_d = FLUSH;
      FLUSH:   if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: acceptance, array-port arbitration and occupancy update.
  always_comb begin
    busy_c = (count_q == CW'(WB_DEPTH)) || (state_q == FLUSH);
`ifndef DMEM_WB_FWD_EN
    busy_c = busy_c || (!bus.CEN && bus.WEN && (count_q != '0));
`endif
    wr_acc  = !bus.CEN && !bus.WEN && !busy_c;
    rd_acc  = !bus.CEN &&  bus.WEN && !busy_c;
    rd_miss = rd_acc && !hit;
    push    = wr_acc;
    // A read miss owns the array port; a write cycle does not retire an entry.
    pop     = (count_q != '0) && !rd_miss && !wr_acc;
    count_d = count_q;
    if (push && !pop) begin
      count_d = CW'(count_q + 1'b1);
    end else if (pop && !push) begin
      count_d = CW'(count_q - 1'b1);
    end
  end

  // Pointers, occupancy and registered read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      q_reg      <= '0;
      q_valid_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= PW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
      count_q   <= count_d;
      q_valid_q <= rd_acc;
      if (rd_acc) q_reg <= rd_data;
      if (!bus.CEN && !bus.WEN && busy_c) drop_err_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; buffered entries are invalidated via the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_mem[wr_ptr_q] <= '{addr: bus.A, data: bus.D};
    end
    if (pop) begin
      mem[wb_mem[rd_ptr_q].addr] <= wb_mem[rd_ptr_q].data;
    end
  end

  assign bus.Q        = bus.OEN ? '0 : q_reg;
  assign bus.q_valid  = q_valid_q;
  assign bus.busy     = busy_c;
  assign bus.drop_err = drop_err_q;

endmodule

// File: tb/tb_dmem_wb_responder.sv
// Directed scoreboard bench for dmem_wb_responder (WB_DEPTH=4, AW=7).
// Expected read data is queued when a read is issued and compared when q_valid appears.
module tb_dmem_wb_responder;

  localparam int unsigned AW = 7;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_wb_if #(.AW(AW)) bus ();

  dmem_wb_responder #(.WB_DEPTH(4), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cen, input logic wen, input logic oen,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic fl);
    bus.CEN   = cen;
    bus.WEN   = wen;
    bus.OEN   = oen;
    bus.A     = a;
    bus.D     = d;
    bus.flush = fl;
  endtask

  // One clock with busy checked before the edge and the response checked after it.
  task automatic step(input string tag, input logic exp_busy, input logic rd, input logic [31:0] rd_exp);
    logic [31:0] e;
    #1;
    chk({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    if (rd) sb.push_back(rd_exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".q_valid"}, 32'(bus.q_valid), 32'(rd));
    if (bus.q_valid && (sb.size() > 0)) begin
      e = sb.pop_front();
      chk({tag, ".Q"}, bus.Q, bus.OEN ? 32'h0 : e);
    end
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                    input logic fl, input logic exp_busy);
    drive(1'b0, 1'b0, 1'b0, a, d, fl);
    step(tag, exp_busy, 1'b0, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic oen,
                    input logic exp_busy, input logic acc, input logic [31:0] d);
    drive(1'b0, 1'b1, oen, a, 32'h0, 1'b0);
    step(tag, exp_busy, acc, d);
  endtask

  task automatic idle(input string tag, input logic fl, input logic exp_busy);
    drive(1'b1, 1'b1, 1'b0, '0, 32'h0, fl);
    step(tag, exp_busy, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, '0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'h0);
    chk("rst.q_valid", 32'(bus.q_valid), 32'h0);
    chk("rst.drop_err", 32'(bus.drop_err), 32'h0);
    chk("rst.Q", bus.Q, 32'h0);
    rst = 1'b0;

    // Write then immediate read of the same word.
    wr("t36w", 7'd5, 32'h1234_5678, 1'b0, 1'b0);
`ifdef DMEM_WB_FWD_EN
    rd("t36r", 7'd5, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
`else
    rd("t36s", 7'd5, 1'b0, 1'b1, 1'b0, 32'h0);
    rd("t36r", 7'd5, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
`endif
    idle("t36i", 1'b0, 1'b0);

    // Two writes to one address: newest data must be returned.
    wr("t37w1", 7'd3, 32'hAAAA_0001, 1'b0, 1'b0);
    wr("t37w2", 7'd3, 32'hAAAA_0002, 1'b0, 1'b0);
`ifdef DMEM_WB_FWD_EN
    rd("t37r", 7'd3, 1'b0, 1'b0, 1'b1, 32'hAAAA_0002);
`else
    rd("t37s1", 7'd3, 1'b0, 1'b1, 1'b0, 32'h0);
    rd("t37s2", 7'd3, 1'b0, 1'b1, 1'b0, 32'h0);
    rd("t37r", 7'd3, 1'b0, 1'b0, 1'b1, 32'hAAAA_0002);
`endif
    idle("t37i", 1'b0, 1'b0);
    chk("t37.drop_err", 32'(bus.drop_err), 32'h0);

    // Overfill: fifth write is dropped, sixth is accepted after one drain cycle.
    for (int i = 0; i < 4; i++) begin
      wr("t38w", 7'(8'h10 + i), 32'h3800_0000 + 32'(i), 1'b0, 1'b0);
    end
    chk("t38.drop_err_pre", 32'(bus.drop_err), 32'h0);
    wr("t38w5", 7'h14, 32'h3800_0004, 1'b0, 1'b1);
    chk("t38.drop_err_set", 32'(bus.drop_err), 32'h1);
    wr("t38w6", 7'h15, 32'h3800_0005, 1'b0, 1'b0);
    chk("t38.drop_err_sticky", 32'(bus.drop_err), 32'h1);
    idle("t38d0", 1'b0, 1'b1);
    idle("t38d1", 1'b0, 1'b0);
    idle("t38d2", 1'b0, 1'b0);
    idle("t38d3", 1'b0, 1'b0);
    rd("t38r0", 7'h10, 1'b0, 1'b0, 1'b1, 32'h3800_0000);
    rd("t38r5", 7'h15, 1'b0, 1'b0, 1'b1, 32'h3800_0005);
    rd("t38r3", 7'h13, 1'b0, 1'b0, 1'b1, 32'h3800_0003);

    // Three entries then flush: exactly three busy cycles, then empty flush stays idle.
    wr("t39w0", 7'h20, 32'h3900_0020, 1'b0, 1'b0);
    wr("t39w1", 7'h21, 32'h3900_0021, 1'b0, 1'b0);
    wr("t39w2", 7'h22, 32'h3900_0022, 1'b1, 1'b0);
    idle("t39f1", 1'b1, 1'b1);
    idle("t39f2", 1'b1, 1'b1);
    idle("t39f3", 1'b1, 1'b1);
    idle("t39f4", 1'b1, 1'b0);
    idle("t39f5", 1'b1, 1'b0);
    rd("t39r0", 7'h20, 1'b0, 1'b0, 1'b1, 32'h3900_0020);
    rd("t39r1", 7'h21, 1'b0, 1'b0, 1'b1, 32'h3900_0021);
    rd("t39r2", 7'h22, 1'b0, 1'b0, 1'b1, 32'h3900_0022);

    // Reset in the middle of a flush discards the undrained entry.
    wr("t40p", 7'h31, 32'h0BAD_0031, 1'b0, 1'b0);
    idle("t40pd", 1'b0, 1'b0);
    wr("t40w0", 7'h30, 32'hC0DE_0030, 1'b0, 1'b0);
    wr("t40w1", 7'h31, 32'hC0DE_0031, 1'b1, 1'b0);
    idle("t40f1", 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("t40.busy", 32'(bus.busy), 32'h0);
    chk("t40.q_valid", 32'(bus.q_valid), 32'h0);
    chk("t40.drop_err", 32'(bus.drop_err), 32'h0);
    chk("t40.Q", bus.Q, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd("t40r1", 7'h31, 1'b0, 1'b0, 1'b1, 32'h0BAD_0031);
    rd("t40r0", 7'h30, 1'b0, 1'b0, 1'b1, 32'hC0DE_0030);

    // Top address with output gated, then ungated.
    wr("t41w", 7'h7F, 32'h7F7F_0001, 1'b0, 1'b0);
    idle("t41d", 1'b0, 1'b0);
    rd("t41r", 7'h7F, 1'b1, 1'b0, 1'b1, 32'h7F7F_0001);
    chk("t41.Q_gated", bus.Q, 32'h0);
    drive(1'b1, 1'b1, 1'b0, '0, 32'h0, 1'b0);
    #1;
    chk("t41.Q_open", bus.Q, 32'h7F7F_0001);
    step("t41i", 1'b0, 1'b0, 32'h0);
    chk("t41.Q_hold", bus.Q, 32'h7F7F_0001);
    chk("sb.empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
